// File: rtl/cntry_sensor_qualifier.sv
// rtl/cntry_sensor_qualifier.sv - country-road car request qualifier: sync, debounce, arm, serve cap, hold-off
//
// Purpose:
//    Turns the raw country stop-line loop detector into the car-waiting request X
//    for the highway/country signal controller. The raw input is synchronised
//    and debounced, and arrivals are counted. X is requested only after a
//    sustained demand. X is released when the controller's country light leaves
//    green, when the sensor clears, or when the green time hits its cap. A
//    hold-off period then keeps the highway in priority.
//
// Ports:
//    clock       in   rising-edge system clock
//    clear_n     in   synchronous active-low reset
//    sensor_raw  in   asynchronous loop detector, 1 = vehicle present
//    cntry       in   country light: 0 RED, 1 YELLOW, 2 GREEN, 3 treated as RED
//    X           out  car-waiting request to the controller
//    sensor_db   out  debounced sensor level
//    car_count   out  arrivals pending service, saturating
//    timeout     out  one-cycle pulse when the green cap expires

module cntry_sensor_qualifier #(
   parameter int DEBOUNCE   = 4,
   parameter int ARM_CYCLES = 8,
   parameter int MAX_GREEN  = 32,
   parameter int HOLDOFF    = 16,
   parameter int CNT_W      = 4
) (
   input  logic             clock,
   input  logic             clear_n,
   input  logic             sensor_raw,
   input  logic [1:0]       cntry,
   output logic             X,
   output logic             sensor_db,
   output logic [CNT_W-1:0] car_count,
   output logic             timeout
);

   // One shared timer serves ARM, SERVE and HOLDOFF; size it for the longest.
   localparam int T_MAX0 = (ARM_CYCLES > MAX_GREEN) ? ARM_CYCLES : MAX_GREEN;
   localparam int T_MAX  = (T_MAX0 > HOLDOFF) ? T_MAX0 : HOLDOFF;
   localparam int T_W    = (T_MAX > 1) ? $clog2(T_MAX) : 1;
   localparam int DB_W   = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

   localparam logic [T_W-1:0]   ARM_LAST   = T_W'(ARM_CYCLES - 1);
   localparam logic [T_W-1:0]   GREEN_LAST = T_W'(MAX_GREEN - 1);
   localparam logic [T_W-1:0]   HOLD_LAST  = T_W'(HOLDOFF - 1);
   localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE - 1);
   localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
   localparam logic [1:0]       LIGHT_GREEN = 2'd2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARM,
      S_REQ,
      S_SERVE,
      S_HOLD
   } state_t;

   logic             r_sync1;
   logic             r_sync2;
   logic             r_db;
   logic             r_db_q;
   logic [DB_W-1:0]  r_db_cnt;
   logic [CNT_W-1:0] r_count;
   logic [T_W-1:0]   r_tmr;
   logic             r_x;
   logic             r_timeout;
   state_t           r_state;

   logic             w_rise;
   logic             w_demand;
   logic             w_green;
   state_t           w_state_nxt;
   logic [T_W-1:0]   w_tmr_nxt;
   logic [CNT_W-1:0] w_count_nxt;
   logic             w_x_nxt;
   logic             w_timeout_nxt;

   // Two-flop synchroniser followed by a persistence counter: sensor_db only
   // follows s_sync after DEBOUNCE consecutive differing samples.
   always_ff @(posedge clock) begin
      if (!clear_n) begin
         r_sync1  <= 1'b0;
         r_sync2  <= 1'b0;
         r_db     <= 1'b0;
         r_db_q   <= 1'b0;
         r_db_cnt <= '0;
      end else begin
         r_sync1 <= sensor_raw;
         r_sync2 <= r_sync1;
         r_db_q  <= r_db;
         if (r_sync2 == r_db) begin
            r_db_cnt <= '0;
         end else if (r_db_cnt == DB_LAST) begin
            r_db     <= ~r_db;
            r_db_cnt <= '0;
         end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
         end
      end
   end

   assign w_rise   = r_db & ~r_db_q;
   assign w_demand = r_db | (r_count != '0);
   assign w_green  = (cntry == LIGHT_GREEN);

   always_ff @(posedge clock) begin
      if (!clear_n) begin
         r_state   <= S_IDLE;
         r_tmr     <= '0;
         r_count   <= '0;
         r_x       <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_tmr     <= w_tmr_nxt;
         r_count   <= w_count_nxt;
         r_x       <= w_x_nxt;
         r_timeout <= w_timeout_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_tmr_nxt     = r_tmr;
      w_timeout_nxt = 1'b0;
      w_count_nxt   = (w_rise && (r_count != CNT_MAX)) ? r_count + 1'b1 : r_count;

      case (r_state)
         S_IDLE: begin
            if (w_demand) begin
               w_state_nxt = S_ARM;
               w_tmr_nxt   = '0;
            end
         end
         S_ARM: begin
            if (!w_demand) begin
               w_state_nxt = S_IDLE;
            end else if (r_tmr == ARM_LAST) begin
               w_state_nxt = S_REQ;
            end else begin
               w_tmr_nxt = r_tmr + 1'b1;
            end
         end
         S_REQ: begin
            if (w_green) begin
               w_state_nxt = S_SERVE;
               w_count_nxt = '0;
               w_tmr_nxt   = '0;
            end
         end
         S_SERVE: begin
            // Arrivals during green are absorbed by the service, not counted.
            w_count_nxt = r_count;
            if (r_tmr == GREEN_LAST) begin
               w_state_nxt   = S_HOLD;
               w_timeout_nxt = 1'b1;
               w_count_nxt   = CNT_W'(r_db);
               w_tmr_nxt     = '0;
            end else if (!r_db) begin
               w_state_nxt = S_HOLD;
               w_count_nxt = '0;
               w_tmr_nxt   = '0;
            end else if (!w_green) begin
               // Controller pre-empted: the car still on the loop stays pending.
               w_state_nxt = S_HOLD;
               w_count_nxt = CNT_W'(r_db);
               w_tmr_nxt   = '0;
            end else begin
               w_tmr_nxt = r_tmr + 1'b1;
            end
         end
         S_HOLD: begin
            if (r_tmr == HOLD_LAST) begin
               w_state_nxt = S_IDLE;
               w_tmr_nxt   = '0;
            end else begin
               w_tmr_nxt = r_tmr + 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_tmr_nxt   = '0;
         end
      endcase

      w_x_nxt = (w_state_nxt == S_REQ) || (w_state_nxt == S_SERVE);
   end

   assign X         = r_x;
   assign sensor_db = r_db;
   assign car_count = r_count;
   assign timeout   = r_timeout;

endmodule
